// File: rtl/data_bus_controller.sv
// data_bus_controller
// Sequences single-outstanding CPU load/store requests onto the RAM and IO
// data-bus targets. It drives the request address into an external registered
// address decoder. When the decoder's selects are valid it routes the transfer
// to the chosen target, then returns read data or an error to the CPU.
//
// Optional feature: define BUS_TIMEOUT_EN to enable the bus watchdog. The
// watchdog aborts a WAIT state after TIMEOUT_CYCLES cycles without an ack.
module data_bus_controller #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  // CPU data port
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  // address decoder
  output logic [31:0] dec_addr_o,
  input  logic        ram_select_i,
  input  logic        io_select_i,
  // targets
  output logic        ram_req_o,
  output logic        io_req_o,
  output logic [31:0] tgt_addr_o,
  output logic        tgt_we_o,
  output logic [3:0]  tgt_be_o,
  output logic [31:0] tgt_wdata_o,
  input  logic        ram_ack_i,
  input  logic        io_ack_i,
  input  logic [31:0] ram_rdata_i,
  input  logic [31:0] io_rdata_i
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECODE   = 3'd1,
    ST_ROUTE    = 3'd2,
    ST_WAIT_RAM = 3'd3,
    ST_WAIT_IO  = 3'd4,
    ST_RESP     = 3'd5
  } state_t;

  state_t      state_r, state_s;

  // latched request fields; these directly drive the decoder and target buses
  logic [31:0] addr_r, addr_s;
  logic        we_r, we_s;
  logic [3:0]  be_r, be_s;
  logic [31:0] wdata_r, wdata_s;

  // registered handshake outputs
  logic        ram_req_r, ram_req_s;
  logic        io_req_r, io_req_s;
  logic        ready_r, ready_s;
  logic [31:0] rdata_r, rdata_s;
  logic        err_r, err_s;

  // ack and read data of the target currently being waited on
  logic        ack_s;
  logic [31:0] tgt_rdata_s;

`ifdef BUS_TIMEOUT_EN
  logic [15:0] wd_cnt_r, wd_cnt_s;
  logic [15:0] wd_cnt_inc_s;
  logic        wd_term_s;

  // watchdog terminal count: the wait cycle that would bring the count up to the limit
  always_comb begin
    wd_cnt_inc_s = wd_cnt_r + 16'd1;
    wd_term_s    = (wd_cnt_inc_s == 16'(TIMEOUT_CYCLES));
  end
`else
  // the timeout limit has no effect when the watchdog is compiled out
  logic [15:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 16'(TIMEOUT_CYCLES);
`endif

  // select the ack/read-data pair of the target matching the current wait state
  always_comb begin
    ack_s       = 1'b0;
    tgt_rdata_s = 32'h0000_0000;
    case (state_r)
      ST_WAIT_RAM: begin
        ack_s       = ram_ack_i;
        tgt_rdata_s = ram_rdata_i;
      end
      ST_WAIT_IO: begin
        ack_s       = io_ack_i;
        tgt_rdata_s = io_rdata_i;
      end
      default: begin
        ack_s       = 1'b0;
        tgt_rdata_s = 32'h0000_0000;
      end
    endcase
  end

  // next-state and next-output logic; everything holds unless a state changes it
  always_comb begin
    state_s   = state_r;
    addr_s    = addr_r;
    we_s      = we_r;
    be_s      = be_r;
    wdata_s   = wdata_r;
    ram_req_s = ram_req_r;
    io_req_s  = io_req_r;
    ready_s   = 1'b0;
    rdata_s   = rdata_r;
    err_s     = err_r;
`ifdef BUS_TIMEOUT_EN
    wd_cnt_s  = wd_cnt_r;
`endif

    case (state_r)
      ST_IDLE: begin
        if (req_i) begin
          addr_s  = addr_i;
          we_s    = we_i;
          be_s    = be_i;
          wdata_s = wdata_i;
          state_s = ST_DECODE;
        end else begin
          state_s = ST_IDLE;
        end
      end

      // the decoder registers its selects from the latched address this cycle
      ST_DECODE: begin
        state_s = ST_ROUTE;
      end

      ST_ROUTE: begin
`ifdef BUS_TIMEOUT_EN
        wd_cnt_s = 16'd0;
`endif
        if (ram_select_i) begin
          // RAM takes priority when the decoder reports overlapping regions
          ram_req_s = 1'b1;
          state_s   = ST_WAIT_RAM;
        end else if (io_select_i) begin
          io_req_s  = 1'b1;
          state_s   = ST_WAIT_IO;
        end else begin
          ready_s   = 1'b1;
          err_s     = 1'b1;
          rdata_s   = 32'h0000_0000;
          state_s   = ST_RESP;
        end
      end

      ST_WAIT_RAM, ST_WAIT_IO: begin
        if (ack_s) begin
          // an ack arriving on the watchdog terminal cycle still completes normally
          ram_req_s = 1'b0;
          io_req_s  = 1'b0;
          rdata_s   = we_r ? 32'h0000_0000 : tgt_rdata_s;
          err_s     = 1'b0;
          ready_s   = 1'b1;
          state_s   = ST_RESP;
        end else begin
`ifdef BUS_TIMEOUT_EN
          if (wd_term_s) begin
            ram_req_s = 1'b0;
            io_req_s  = 1'b0;
            rdata_s   = 32'h0000_0000;
            err_s     = 1'b1;
            ready_s   = 1'b1;
            state_s   = ST_RESP;
          end else begin
            wd_cnt_s  = wd_cnt_inc_s;
          end
`else
          state_s = state_r;
`endif
        end
      end

      // ready_o is high during this cycle only; rdata_o/err_o keep their values
      ST_RESP: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s   = ST_IDLE;
        ram_req_s = 1'b0;
        io_req_s  = 1'b0;
      end
    endcase
  end

  // state and output registers with synchronous reset abandoning any transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      addr_r    <= 32'h0000_0000;
      we_r      <= 1'b0;
      be_r      <= 4'h0;
      wdata_r   <= 32'h0000_0000;
      ram_req_r <= 1'b0;
      io_req_r  <= 1'b0;
      ready_r   <= 1'b0;
      rdata_r   <= 32'h0000_0000;
      err_r     <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      wd_cnt_r  <= 16'd0;
`endif
    end else begin
      state_r   <= state_s;
      addr_r    <= addr_s;
      we_r      <= we_s;
      be_r      <= be_s;
      wdata_r   <= wdata_s;
      ram_req_r <= ram_req_s;
      io_req_r  <= io_req_s;
      ready_r   <= ready_s;
      rdata_r   <= rdata_s;
      err_r     <= err_s;
`ifdef BUS_TIMEOUT_EN
      wd_cnt_r  <= wd_cnt_s;
`endif
    end
  end

  assign ready_o     = ready_r;
  assign rdata_o     = rdata_r;
  assign err_o       = err_r;
  assign dec_addr_o  = addr_r;
  assign ram_req_o   = ram_req_r;
  assign io_req_o    = io_req_r;
  assign tgt_addr_o  = addr_r;
  assign tgt_we_o    = we_r;
  assign tgt_be_o    = be_r;
  assign tgt_wdata_o = wdata_r;

endmodule

// File: tb/tb_data_bus_controller.sv
// Directed testbench for data_bus_controller. A small registered decoder model
// maps 0x0xxx_xxxx to RAM and 0xFxxx_xxxx to IO; everything else is unmapped.
// Timeout checks are compiled in when BUS_TIMEOUT_EN is defined.
module tb_data_bus_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] addr = 32'h0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic        ready_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [31:0] dec_addr_o;
  logic        ram_select = 1'b0;
  logic        io_select = 1'b0;
  logic        ram_req_o, io_req_o;
  logic [31:0] tgt_addr_o, tgt_wdata_o;
  logic        tgt_we_o;
  logic [3:0]  tgt_be_o;
  logic        ram_ack = 1'b0;
  logic        io_ack = 1'b0;
  logic [31:0] ram_rdata = 32'h0;
  logic [31:0] io_rdata = 32'h0;

  int total = 0;
  int bad = 0;

  data_bus_controller #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_i(req), .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
    .ready_o(ready_o), .rdata_o(rdata_o), .err_o(err_o),
    .dec_addr_o(dec_addr_o), .ram_select_i(ram_select), .io_select_i(io_select),
    .ram_req_o(ram_req_o), .io_req_o(io_req_o),
    .tgt_addr_o(tgt_addr_o), .tgt_we_o(tgt_we_o), .tgt_be_o(tgt_be_o),
    .tgt_wdata_o(tgt_wdata_o),
    .ram_ack_i(ram_ack), .io_ack_i(io_ack),
    .ram_rdata_i(ram_rdata), .io_rdata_i(io_rdata)
  );

  always #5 clk = ~clk;

  // registered address decoder model
  always @(posedge clk) begin
    if (rst) begin
      ram_select <= 1'b0;
      io_select  <= 1'b0;
    end else begin
      ram_select <= (dec_addr_o[31:28] == 4'h0);
      io_select  <= (dec_addr_o[31:28] == 4'hF);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and play the target side. tgt: 0 none, 1 RAM, 2 IO.
  // The chosen target acks in its (wait_n+1)-th request-high cycle.
  // spur holds the non-selected RAM ack high throughout an IO transfer.
  // lat counts clock edges from acceptance until ready_o is seen.
  task automatic run_txn(input string tag, input logic [31:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] wd, input int tgt,
                         input int wait_n, input logic [31:0] rd, input logic spur,
                         output int lat, output int ram_hi, output int io_hi,
                         output logic [3:0] cap_be, output logic [31:0] cap_wd);
    logic done;
    req = 1'b1; addr = a; we = w; be = b; wdata = wd;
    lat = 0; ram_hi = 0; io_hi = 0; done = 1'b0;
    cap_be = 4'h0; cap_wd = 32'h0;
    step();
    for (int c = 0; c < 40 && !done; c++) begin
      ram_ack = 1'b0;
      io_ack  = 1'b0;
      if (spur) begin
        ram_ack   = 1'b1;
        ram_rdata = 32'hBAD0_BAD0;
      end
      if (ram_req_o) begin
        ram_hi++;
        if (ram_hi == 1) begin
          cap_be = tgt_be_o;
          cap_wd = tgt_wdata_o;
        end
        if (tgt == 1 && ram_hi == wait_n + 1) begin
          ram_ack   = 1'b1;
          ram_rdata = rd;
        end
      end
      if (io_req_o) begin
        io_hi++;
        if (io_hi == 1) begin
          cap_be = tgt_be_o;
          cap_wd = tgt_wdata_o;
        end
        if (tgt == 2 && io_hi == wait_n + 1) begin
          io_ack   = 1'b1;
          io_rdata = rd;
        end
      end
      step();
      lat++;
      if (ready_o) done = 1'b1;
    end
    req = 1'b0; ram_ack = 1'b0; io_ack = 1'b0;
    check({tag, "_completed"}, 32'(done), 32'd1);
  endtask

  int          lat, ram_hi, io_hi;
  logic [3:0]  cbe;
  logic [31:0] cwd;

  initial begin
    // reset state
    step(); step();
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_ram_req", 32'(ram_req_o), 32'd0);
    check("rst_io_req", 32'(io_req_o), 32'd0);
    check("rst_dec_addr", dec_addr_o, 32'h0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_tgt_be", 32'(tgt_be_o), 32'd0);
    rst = 1'b0;
    step();

    // RAM load, zero-wait ack
    run_txn("ld_ram", 32'h0000_0100, 1'b0, 4'hF, 32'h0, 1, 0, 32'hDEAD_BEEF, 1'b0,
            lat, ram_hi, io_hi, cbe, cwd);
    check("ld_ram_lat", 32'(lat), 32'd3);
    check("ld_ram_rdata", rdata_o, 32'hDEAD_BEEF);
    check("ld_ram_err", 32'(err_o), 32'd0);
    check("ld_ram_io_hi", 32'(io_hi), 32'd0);
    check("ld_ram_ram_hi", 32'(ram_hi), 32'd1);
    step();
    check("ld_ram_ready_1cyc", 32'(ready_o), 32'd0);
    check("ld_ram_rdata_hold", rdata_o, 32'hDEAD_BEEF);

    // IO store, three wait cycles
    run_txn("st_io", 32'hF000_0004, 1'b1, 4'b0011, 32'h1234_5678, 2, 3, 32'h5555_AAAA,
            1'b0, lat, ram_hi, io_hi, cbe, cwd);
    check("st_io_lat", 32'(lat), 32'd6);
    check("st_io_io_hi", 32'(io_hi), 32'd4);
    check("st_io_ram_hi", 32'(ram_hi), 32'd0);
    check("st_io_be", 32'(cbe), 32'h3);
    check("st_io_wdata", cwd, 32'h1234_5678);
    check("st_io_rdata", rdata_o, 32'h0);
    check("st_io_err", 32'(err_o), 32'd0);
    step();

    // unmapped load
    run_txn("unmap", 32'h8000_0000, 1'b0, 4'hF, 32'h0, 0, 0, 32'h0, 1'b0,
            lat, ram_hi, io_hi, cbe, cwd);
    check("unmap_lat", 32'(lat), 32'd2);
    check("unmap_err", 32'(err_o), 32'd1);
    check("unmap_rdata", rdata_o, 32'h0);
    check("unmap_no_req", 32'(ram_hi + io_hi), 32'd0);
    step();

    // IO load with a spurious RAM ack held high the whole time
    run_txn("ld_io_spur", 32'hF000_0010, 1'b0, 4'hF, 32'h0, 2, 1, 32'h0BAD_F00D, 1'b1,
            lat, ram_hi, io_hi, cbe, cwd);
    check("ld_io_spur_lat", 32'(lat), 32'd4);
    check("ld_io_spur_rdata", rdata_o, 32'h0BAD_F00D);
    check("ld_io_spur_err", 32'(err_o), 32'd0);
    step();

    // RAM store returns zero read data even with live RAM read data
    run_txn("st_ram", 32'h0000_0200, 1'b1, 4'b1100, 32'hA5A5_5A5A, 1, 1, 32'hFFFF_FFFF,
            1'b0, lat, ram_hi, io_hi, cbe, cwd);
    check("st_ram_lat", 32'(lat), 32'd4);
    check("st_ram_rdata", rdata_o, 32'h0);
    check("st_ram_be", 32'(cbe), 32'hC);
    step();

    // reset while waiting on RAM
    req = 1'b1; addr = 32'h0000_0300; we = 1'b0; be = 4'hF; wdata = 32'h0;
    step();                 // accepted
    req = 1'b0;
    step(); step();         // DECODE -> ROUTE -> WAIT_RAM
    check("wr_ram_req_before_rst", 32'(ram_req_o), 32'd1);
    step();
    rst = 1'b1;
    step();
    check("wr_rst_ram_req", 32'(ram_req_o), 32'd0);
    check("wr_rst_dec_addr", dec_addr_o, 32'h0);
    check("wr_rst_tgt_addr", tgt_addr_o, 32'h0);
    check("wr_rst_ready_err", 32'({ready_o, err_o, io_req_o, tgt_we_o}), 32'd0);
    check("wr_rst_rdata", rdata_o, 32'h0);
    rst = 1'b0;
    step();
    run_txn("after_rst", 32'h0000_0000, 1'b0, 4'hF, 32'h0, 1, 0, 32'hCAFE_F00D, 1'b0,
            lat, ram_hi, io_hi, cbe, cwd);
    check("after_rst_lat", 32'(lat), 32'd3);
    check("after_rst_rdata", rdata_o, 32'hCAFE_F00D);
    step();

`ifdef BUS_TIMEOUT_EN
    // RAM never acks: watchdog aborts after four wait cycles
    run_txn("tmo", 32'h0000_0400, 1'b0, 4'hF, 32'h0, 0, 0, 32'h0, 1'b0,
            lat, ram_hi, io_hi, cbe, cwd);
    check("tmo_ram_hi", 32'(ram_hi), 32'd4);
    check("tmo_lat", 32'(lat), 32'd6);
    check("tmo_err", 32'(err_o), 32'd1);
    check("tmo_rdata", rdata_o, 32'h0);
    step();

    // ack on the terminal cycle wins
    run_txn("tmo_ack", 32'h0000_0404, 1'b0, 4'hF, 32'h0, 1, 3, 32'h1357_9BDF, 1'b0,
            lat, ram_hi, io_hi, cbe, cwd);
    check("tmo_ack_lat", 32'(lat), 32'd6);
    check("tmo_ack_err", 32'(err_o), 32'd0);
    check("tmo_ack_rdata", rdata_o, 32'h1357_9BDF);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_bus_controller.md
# data_bus_controller

Sequences CPU load/store requests onto the RAM and IO regions of the data bus. It sits between the CPU data port and the memory targets and drives the address into the registered address decoder. One cycle later it samples the decoder's `ram_select`/`io_select` outputs and routes the transfer to the selected target. It returns read data, or an error for unmapped addresses, to the CPU through a single-outstanding request/ready handshake.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: number of WAIT cycles without an ack before the bus watchdog aborts. Used only when `BUS_TIMEOUT_EN` is defined. Range 1..65535.

Ports:
- `clk` in 1: the single clock; everything samples on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_i` in 1: CPU request. Held high with stable fields until `ready_o`.
- `addr_i` in 32: byte address.
- `we_i` in 1: 1 = store, 0 = load.
- `be_i` in 4: byte enables.
- `wdata_i` in 32: store data.
- `ready_o` out 1: one-cycle completion pulse.
- `rdata_o` out 32: load data, valid while `ready_o` is high.
- `err_o` out 1: error flag, valid while `ready_o` is high.
- `dec_addr_o` out 32: address driven to the address decoder.
- `ram_select_i` in 1: decoder output, registered one cycle after `dec_addr_o`.
- `io_select_i` in 1: decoder output, registered one cycle after `dec_addr_o`.
- `ram_req_o`, `io_req_o` out 1 each: target request. Held high until the matching ack.
- `tgt_addr_o` out 32, `tgt_we_o` out 1, `tgt_be_o` out 4, `tgt_wdata_o` out 32: shared target fields, valid while either request is high.
- `ram_ack_i`, `io_ack_i` in 1 each: single-cycle target acknowledge.
- `ram_rdata_i`, `io_rdata_i` in 32 each: target read data, valid with the matching ack.

## Operation
The controller is a state machine with states IDLE, DECODE, ROUTE, WAIT_RAM, WAIT_IO and RESP.

- **IDLE:** when `req_i` is high, latch `addr_i`, `we_i`, `be_i` and `wdata_i` into the request registers and go to DECODE. Otherwise stay in IDLE.
- **Decoder drive:** `dec_addr_o` is the latched address at all times. `tgt_*` outputs are the latched fields.
- **DECODE:** lasts exactly one cycle while the decoder registers its selects. Then go to ROUTE.
- **ROUTE:** sample the selects.
  - `ram_select_i` high: set `ram_req_o` and go to WAIT_RAM. If both selects are high, RAM wins.
  - Otherwise `io_select_i` high: set `io_req_o` and go to WAIT_IO.
  - Neither high: go to RESP with `err_o`=1 and `rdata_o`=0.
- **WAIT_RAM / WAIT_IO:** on the matching ack:
  - clear the request;
  - capture read data (loads only; stores capture 0);
  - set `err_o`=0;
  - go to RESP.
  - Acks from the non-selected target are ignored.
- **RESP:** `ready_o`=1 for exactly one cycle, then go to IDLE. `rdata_o` and `err_o` hold their values until the next RESP.
- **Handshake rules:**
  - Only one request is outstanding at a time.
  - `req_i` arriving in any non-IDLE state is not accepted until IDLE.
  - A `req_i` still high in the IDLE cycle after RESP is accepted as a new request.
- **Reset:** reset during any state returns to IDLE and abandons the in-flight transfer. Targets must tolerate `*_req_o` dropping without an ack.

## Timing
- **Reset values:**
  - `ready_o`, `err_o`, `ram_req_o`, `io_req_o`, `tgt_we_o` = 0.
  - `rdata_o`, `dec_addr_o`, `tgt_addr_o`, `tgt_wdata_o` = 0.
  - `tgt_be_o` = 0.
  - State = IDLE. Watchdog counter = 0.
- All outputs are registered.
- **Cycle numbering:** request accepted at edge E0. E1: DECODE→ROUTE. E2: request to target asserted.
- **Mapped access:** a zero-wait ack in the cycle after E2 is sampled at E3, and `ready_o` is high in the cycle after E3. Minimum latency from acceptance to `ready_o` is 4 cycles; each ack wait cycle adds 1.
- **Unmapped access:** `ready_o` with `err_o`=1 is high in the cycle after E2 (3 cycles).
- **Back-to-back:** the next request can be accepted at the edge that ends the IDLE cycle following RESP, i.e. throughput is one transfer per 5 or more cycles.
- **Ack timing:** an ack in the same cycle that the request first rises (after E2) is valid.

## Configuration
- **With `BUS_TIMEOUT_EN` defined:**
  - A 16-bit counter clears on entry to WAIT_RAM/WAIT_IO and increments each wait cycle without an ack.
  - When it equals `TIMEOUT_CYCLES`, the controller drops the request and goes to RESP with `err_o`=1 and `rdata_o`=0.
  - An ack arriving in the same cycle as the terminal count wins, giving a normal response.
- **Without it:** there is no counter, and WAIT states hold indefinitely until ack or reset.

## Test plan
- Load from 0x0000_0100 with RAM acking zero-wait and `ram_rdata_i`=0xDEADBEEF → `ready_o` 4 cycles after acceptance, `rdata_o`=0xDEADBEEF, `err_o`=0, `io_req_o` never high.
- Store to 0xF000_0004, `be_i`=4'b0011, `wdata_i`=0x1234_5678, IO acks after 3 wait cycles → `io_req_o` high 4 cycles with `tgt_be_o`=0011 and `tgt_wdata_o`=0x12345678; `ready_o` 7 cycles after acceptance with `rdata_o`=0.
- Load from 0x8000_0000 (unmapped) → no target request, `ready_o` 3 cycles after acceptance with `err_o`=1, `rdata_o`=0.
- `rst` asserted for one cycle while in WAIT_RAM → next cycle all outputs are at their reset values; a new load to 0x0000_0000 then completes normally.
- With `BUS_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, RAM never acks → `ram_req_o` drops after 4 wait cycles, then `ready_o` with `err_o`=1. Ack on the terminal cycle → normal response with `err_o`=0.
